// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// seq_divider_if : request/response handshake bundle for seq_divider
// Rev 1.0
// ============================================================================
interface seq_divider_if #(
  parameter int W_n = 64,
  parameter int W_d = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [W_n-1:0] dividend;
  logic [W_d-1:0] divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W_n-1:0] quotient;
  logic [W_d-1:0] remainder;
  logic           div_by_zero;

  // The divider owns the slave side; the requester owns the master side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider : multi-cycle unsigned restoring divider, one quotient bit/clock
// Rev 1.0
// ============================================================================
module seq_divider #(
  parameter int W_n = 64,
  parameter int W_d = 32
) (
  input  logic          Clock,
  input  logic          Resetn,
  seq_divider_if.slave  bus
);

  localparam int CW = $clog2(W_n + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W_n-1:0]  r_q;
  logic [W_d-1:0]  r_d;
  logic [W_d-1:0]  r_r;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [W_n-1:0]  r_quot;
  logic [W_d-1:0]  r_rem;
  logic            r_dbz;

  // The partial remainder is always < D between steps, so it is held in W_d
  // bits; only the shifted value needs the extra bit, where the borrow lands.
  logic [W_d:0]    w_r_sh;
  logic [W_d:0]    w_t;
  logic            w_borrow;
  logic [W_n-1:0]  w_q_next;
  logic [W_d-1:0]  w_r_next;

  assign w_r_sh   = {r_r, r_q[W_n-1]};
  assign w_t      = w_r_sh - {1'b0, r_d};
  assign w_borrow = w_t[W_d];
  assign w_q_next = {r_q[W_n-2:0], ~w_borrow};
  assign w_r_next = w_borrow ? w_r_sh[W_d-1:0] : w_t[W_d-1:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_q        <= bus.dividend;
            r_d        <= bus.divisor;
            r_r        <= '0;
            r_cnt      <= CW'(W_n);
            r_in_ready <= 1'b0;
            if (bus.divisor == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_quot      <= '1;
              r_rem       <= bus.dividend[W_d-1:0];
              r_dbz       <= 1'b1;
            end else begin
              r_state <= BUSY;
              r_dbz   <= 1'b0;
            end
          end
        end

        BUSY: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_quot      <= w_q_next;
            r_rem       <= w_r_next;
          end
        end

        DONE: begin
          // Result registers are left untouched so they persist after DONE.
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// tb_seq_divider : directed + randomized bench for seq_divider
// Rev 1.0
// ============================================================================
module tb_seq_divider;

  localparam int W_n = 64;
  localparam int W_d = 32;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  int   n_cmp  = 0;
  int   n_mis  = 0;

  always #5 Clock = ~Clock;

  seq_divider_if #(.W_n(W_n), .W_d(W_d)) bus ();

  seq_divider #(.W_n(W_n), .W_d(W_d)) u_dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic start_op(input logic [W_n-1:0] dvd, input logic [W_d-1:0] dvs);
    int w = 0;
    while (!bus.in_ready && w < 300) begin
      @(negedge Clock);
      w++;
    end
    check("in_ready_before_op", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge Clock);
    @(negedge Clock);
    bus.in_valid = 1'b0;
    bus.dividend = {$urandom, $urandom};
    bus.divisor  = $urandom;
  endtask

  // Counts accept-relative cycles until out_valid shows up.
  task automatic wait_done(input int exp_lat);
    int c = 0;
    while (!bus.out_valid && c < 200) begin
      @(negedge Clock);
      c++;
    end
    check("latency", c, exp_lat);
  endtask

  task automatic check_result(input logic [W_n-1:0] dvd, input logic [W_d-1:0] dvs);
    logic [W_n-1:0] eq;
    logic [W_d-1:0] er;
    logic           ez;
    logic [127:0]   id;
    if (dvs == 0) begin
      eq = '1;
      er = dvd[W_d-1:0];
      ez = 1'b1;
    end else begin
      eq = dvd / W_n'(dvs);
      er = W_d'(dvd % W_n'(dvs));
      ez = 1'b0;
    end
    check("quotient", bus.quotient, eq);
    check("remainder", bus.remainder, er);
    check("div_by_zero", bus.div_by_zero, ez);
    if (dvs != 0) begin
      id = 128'(bus.quotient) * 128'(dvs) + 128'(bus.remainder);
      check("identity", id, 128'(dvd));
      check("rem_lt_div", bus.remainder < dvs, 1'b1);
    end
  endtask

  task automatic release_result(input int stall);
    bus.out_ready = 1'b0;
    repeat (stall) begin
      @(negedge Clock);
      check("stall_out_valid", bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    @(negedge Clock);
    bus.out_ready = 1'b0;
    check("post_hs_out_valid", bus.out_valid, 1'b0);
    check("post_hs_in_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W_n-1:0] dvd;
    logic [W_d-1:0] dvs;
    logic [31:0]    a;
    logic [31:0]    b;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    // Reset state
    repeat (3) @(negedge Clock);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 1'b0);
    Resetn = 1'b1;
    @(negedge Clock);

    // Basic
    start_op(64'd100, 32'd7);
    wait_done(W_n);
    check("basic_q", bus.quotient, 64'd14);
    check("basic_r", bus.remainder, 32'd2);
    check_result(64'd100, 32'd7);
    release_result(0);

    // Extremes
    start_op('1, 32'hFFFF_FFFF);
    wait_done(W_n);
    check("ext_q", bus.quotient, 64'h0000_0001_0000_0001);
    check_result('1, 32'hFFFF_FFFF);
    release_result(1);
    start_op('1, 32'd1);
    wait_done(W_n);
    check("ext_div1_q", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    check_result('1, 32'd1);
    release_result(0);

    // Divide by zero: DONE straight from the accepting edge
    start_op(64'h1234_5678_9ABC_DEF0, 32'd0);
    wait_done(0);
    check("dbz_r", bus.remainder, 32'h9ABC_DEF0);
    check_result(64'h1234_5678_9ABC_DEF0, 32'd0);
    release_result(2);

    // Backpressure with in_valid activity in DONE
    start_op(64'd1000, 32'd3);
    wait_done(W_n);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.dividend = {$urandom, $urandom};
      bus.divisor  = $urandom;
      @(negedge Clock);
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_in_ready", bus.in_ready, 1'b0);
      check("bp_q", bus.quotient, 64'd333);
      check("bp_r", bus.remainder, 32'd1);
    end
    bus.in_valid = 1'b0;
    release_result(0);
    @(negedge Clock);
    check("bp_no_second_op", bus.in_ready, 1'b1);
    check("bp_held_q", bus.quotient, 64'd333);

    // Reset in the middle of an operation
    start_op({$urandom, $urandom}, 32'd12345);
    repeat (30) @(negedge Clock);
    check("mid_busy", bus.in_ready, 1'b0);
    #2 Resetn = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_quotient", bus.quotient, 0);
    check("arst_remainder", bus.remainder, 0);
    check("arst_in_ready", bus.in_ready, 1'b1);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    start_op(64'd200, 32'd9);
    wait_done(W_n);
    check("post_rst_q", bus.quotient, 64'd22);
    check("post_rst_r", bus.remainder, 32'd2);
    check_result(64'd200, 32'd9);
    release_result(0);

    // Multiplier round trip, with occasional remainder and zero divisor
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      if (b == 0) b = 32'd1;
      dvd = 64'(a) * 64'(b);
      if ($urandom_range(3) == 0) dvd = dvd + 64'($urandom % b);
      dvs = b;
      if ($urandom_range(49) == 0) dvs = '0;
      start_op(dvd, dvs);
      wait_done((dvs == 0) ? 0 : W_n);
      check_result(dvd, dvs);
      if (dvs != 0) check("rt_quot_a", bus.quotient, 64'(a));
      release_result($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider: the inverse operation of the team's widened (no-overflow) multiplier.
- Takes a wide dividend (default 64 bits, the width of a 32x32 product) and a narrower divisor. Returns quotient and remainder.
- Used to scale accumulated matrix-multiply products back down, and to self-check multiplier results.
- Valid/ready handshake on both input and output sides; one quotient bit is resolved per clock.

Parameters:
W_n, 64, dividend and quotient width in bits (>= W_d).
W_d, 32, divisor and remainder width in bits (>= 2).

Ports:
Clock  input  1  single clock; all state updates on posedge Clock.
Resetn  input  1  asynchronous, active-low reset.
in_valid  input  1  dividend/divisor presented.
in_ready  output  1  block can accept an operation; high only in IDLE.
dividend  input  W_n  unsigned dividend, sampled on accept.
divisor  input  W_d  unsigned divisor, sampled on accept.
out_valid  output  1  result available; high only in DONE.
out_ready  input  1  consumer takes the result.
quotient  output  W_n  unsigned quotient.
remainder  output  W_d  unsigned remainder.
div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Interface: one clock, Clock. Reset is asynchronous and active-low, Resetn.
- Reset (Resetn low, immediate, independent of Clock):
  - State goes to IDLE.
  - quotient = 0, remainder = 0, div_by_zero = 0, out_valid = 0, iteration counter = 0.
  - in_ready = 1 once in IDLE.
- An operation in flight is discarded on reset.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from the state register, no combinational path from inputs.
- IDLE:
  - Accept on posedge when in_valid && in_ready.
  - Latch dividend into shift register Q and divisor into D. Clear the partial remainder R (W_d+1 bits). Load counter = W_n.
  - If divisor == 0: go directly to DONE with quotient = all ones, remainder = dividend[W_d-1:0], div_by_zero = 1 (out_valid one cycle after accept).
  - Otherwise go to BUSY, with div_by_zero = 0.
- BUSY, each posedge:
  - Shift {R,Q} left by 1. T = R_shifted - {1'b0,D}.
  - If T non-negative: R = T, Q[0] = 1. Else R = R_shifted, Q[0] = 0.
  - counter decrements; when it goes 1 -> 0, state goes to DONE.
- Latency: out_valid rises exactly W_n cycles after the accepting edge (64 at defaults).
- DONE:
  - quotient = Q, remainder = R[W_d-1:0]. Both stay stable while out_valid = 1.
  - On posedge with out_ready = 1, go to IDLE; out_valid drops the next cycle.
  - Output registers keep their last values after leaving DONE.
  - Throughput: one op per W_n+2 cycles with immediate out_ready.
- in_valid is ignored in BUSY and DONE. There is no accept in the same cycle as the output handshake; a new op can be accepted the cycle after returning to IDLE.
- Inputs dividend/divisor may change freely after accept.
- Arithmetic: quotient*divisor + remainder == dividend, with remainder < divisor, for every non-zero divisor.
- Widths:
  - No truncation of the quotient (W_n bits holds the maximum quotient, divisor = 1).
  - Remainder always fits in W_d.
  - The internal subtract is W_d+1 bits to capture the borrow.

Test Plan:
- Basic (defaults): dividend=100, divisor=7, in_valid 1 cycle -> after 64 cycles out_valid=1, quotient=14, remainder=2, div_by_zero=0. out_ready=1 -> IDLE, in_ready=1 two cycles later.
- Extremes: dividend=0xFFFF_FFFF_FFFF_FFFF, divisor=0xFFFF_FFFF -> quotient=0x0000_0001_0000_0001, remainder=0. Same dividend with divisor=1 -> quotient=dividend, remainder=0.
- Divide by zero: dividend=0x1234_5678_9ABC_DEF0, divisor=0 -> out_valid the next cycle, quotient=all ones, remainder=0x9ABC_DEF0, div_by_zero=1.
- Backpressure and ignore: out_ready held low 10 cycles in DONE, in_valid toggling with new operands -> outputs unchanged, in_ready=0 throughout, no second op started. Release out_ready -> the next op accepted only after IDLE.
- Reset mid-op: Resetn pulsed low at iteration 30 of 64 -> out_valid=0, quotient=0, remainder=0 immediately (asynchronously). A fresh op 200/9 after release -> quotient=22, remainder=2.
- Multiplier round trip: random 32-bit a, b != 0, dividend = a*b (64-bit), divisor = b -> quotient = a, remainder = 0. Run 1000 random vectors plus random out_ready stalls; check the quotient*divisor+remainder identity on every result.
